bus_arbiter_2: RTL and testbench
================================

Name: bus_arbiter_2

Overview:
Two-requester arbiter for the 32-bit host port of the 32-to-16 bridge. Requester 0 is instruction fetch and requester 1 is data.
- Grants one requester at a time, round-robin.
- Latches the granted request into registers and drives the bridge host port from them.
- Routes completion and read data back to the owner.
- A watchdog completes a stalled access with an error flag, then drains the bridge before the next grant.

Parameters:
TIMEOUT, 16'd255, GRANT cycles allowed before a forced error completion; 0 disables the watchdog.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous reset, active-high.
m0_cs, m1_cs  in  1  requester chip select.
m0_addr, m1_addr  in  32  byte address.
m0_wdata, m1_wdata  in  32  write data.
m0_wr_en, m1_wr_en  in  1  1 = write, 0 = read.
m0_bytesel, m1_bytesel  in  4  byte enables; a request is cs && |bytesel.
m0_rdata, m1_rdata  out  32  read data, valid while the matching compl is high.
m0_compl, m1_compl  out  1  single-cycle completion.
m0_err, m1_err  out  1  high with compl when the access timed out.
s_cs  out  1  bridge chip select.
s_addr  out  32  bridge address.
s_wdata  out  32  bridge write data.
s_wr_en  out  1  bridge write enable.
s_bytesel  out  4  bridge byte enables.
s_rdata  in  32  bridge read data.
s_compl  in  1  bridge completion pulse.

Behaviour:
- One clock `clk`; `rst` is asynchronous and active-high. All registers clear on `rst` assertion.
- Reset values: state=IDLE, owner=0, last_grant=1 (m0 wins the first tie), counter=0. All s_* outputs 0. All m*_compl, m*_err and m*_rdata outputs 0.
- States:
  - IDLE:
    - Sample both requests.
    - If only one requests, grant it. If both request, grant the requester that is not last_grant.
    - On a grant, at the clock edge: latch that requester's addr, wdata, wr_en and bytesel into the s_* registers; set s_cs=1; set owner and last_grant; clear counter; go to GRANT.
    - With no request, stay in IDLE with s_* = 0.
  - GRANT:
    - s_* hold the latched values; requester inputs are ignored.
    - Counter increments each cycle.
    - If s_compl: owner's compl=1 and rdata=s_rdata (combinational, same cycle); next state IDLE, s_* cleared at the edge.
    - Else if TIMEOUT!=0 and counter==TIMEOUT-1: owner's compl=1, err=1, rdata=0; next state DRAIN.
    - If s_compl and the timeout condition occur in the same cycle, s_compl wins and err stays 0.
  - DRAIN:
    - Keep driving the latched request so the bridge can finish; no m*_compl is asserted.
    - On s_compl (its data is discarded): next state IDLE, s_* cleared.
- Latency:
  - The request is sampled in IDLE at cycle t; the bridge sees it at t+1.
  - m*_compl occurs in the same cycle as s_compl.
  - At least one IDLE cycle separates transactions. This covers the bridge's post-completion state, where it ignores cs.
- Requester rule: hold cs, addr, wdata, wr_en and bytesel until the compl pulse is sampled, then deassert cs the following cycle. A request still asserted in IDLE is treated as a new access.
- Output gating:
  - The non-owner's compl, err and rdata are always 0.
  - The owner's rdata is 0 except in its compl cycle.
- s_compl arriving in IDLE is ignored.
- Round-robin fairness: with both requesting continuously, grants alternate 0,1,0,1,…
- Reset mid-operation: returns to IDLE immediately and drops s_cs and s_bytesel. The bridge and SDRAM must be reset together with this block; no recovery of a partial access.
- Counter is 16 bits and saturates; it never wraps within GRANT.

Test Plan:
- Single read: m0 reads 0x100 with bytesel=4'hF; bridge returns 0xCAFEF00D 6 cycles after s_cs -> s_addr=0x100 one cycle after request; m0_compl for 1 cycle with m0_rdata=0xCAFEF00D; m1 outputs stay 0.
- Contention: m0 and m1 request in the same IDLE cycle after reset -> m0 granted first; m1 granted after one IDLE cycle; continuous requests from both then alternate grants 0,1,0,1.
- Write latch: m1 writes 0x12345678 to 0x2000 with bytesel=4'b1100, then changes m1_addr and m1_wdata during GRANT -> s_addr=0x2000, s_wdata=0x12345678, s_bytesel=4'b1100 stable until s_compl.
- Timeout: TIMEOUT=8, bridge silent -> m0_compl=1, m0_err=1, m0_rdata=0 in GRANT cycle 8; a later s_compl is absorbed in DRAIN with no m*_compl; an m1 request pending throughout is granted only after DRAIN exits.
- Race: s_compl arrives in the same cycle the counter hits TIMEOUT-1 -> compl with err=0 and rdata=s_rdata.
- Reset: assert rst mid-GRANT -> s_cs, s_bytesel and all compl outputs go 0 without waiting for a clock edge; first request after release is handled normally.

Source files
------------

// File: rtl/bus_arbiter_2_if.sv
// Signal bundle between the two requesters, the arbiter and the bridge host port.
// master = arbiter view; slave = requesters plus bridge (the environment).
interface bus_arbiter_2_if;
    logic        m0_cs;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_wr_en;
    logic [3:0]  m0_bytesel;
    logic [31:0] m0_rdata;
    logic        m0_compl;
    logic        m0_err;

    logic        m1_cs;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_wr_en;
    logic [3:0]  m1_bytesel;
    logic [31:0] m1_rdata;
    logic        m1_compl;
    logic        m1_err;

    logic        s_cs;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_wr_en;
    logic [3:0]  s_bytesel;
    logic [31:0] s_rdata;
    logic        s_compl;

    modport master (
        input  m0_cs, m0_addr, m0_wdata, m0_wr_en, m0_bytesel,
        output m0_rdata, m0_compl, m0_err,
        input  m1_cs, m1_addr, m1_wdata, m1_wr_en, m1_bytesel,
        output m1_rdata, m1_compl, m1_err,
        output s_cs, s_addr, s_wdata, s_wr_en, s_bytesel,
        input  s_rdata, s_compl
    );

    modport slave (
        output m0_cs, m0_addr, m0_wdata, m0_wr_en, m0_bytesel,
        input  m0_rdata, m0_compl, m0_err,
        output m1_cs, m1_addr, m1_wdata, m1_wr_en, m1_bytesel,
        input  m1_rdata, m1_compl, m1_err,
        input  s_cs, s_addr, s_wdata, s_wr_en, s_bytesel,
        output s_rdata, s_compl
    );
endinterface

// File: rtl/bus_arbiter_2.sv
// Round-robin arbiter for two requesters onto the 32-bit bridge host port, with a
// GRANT watchdog that forces an error completion and then drains the bridge.
//
// Handshake: a requester asks with cs && |bytesel and holds its fields until it
// samples its single-cycle compl; the bridge sees s_cs held high until s_compl.
module bus_arbiter_2 #(
    parameter logic [15:0] TIMEOUT = 16'd255
) (
    input  logic              clk,
    input  logic              rst,
    bus_arbiter_2_if.master   bus,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic        owner;
    logic        last_grant;
    logic [15:0] counter;

    logic        s_cs_q;
    logic [31:0] s_addr_q;
    logic [31:0] s_wdata_q;
    logic        s_wr_en_q;
    logic [3:0]  s_bytesel_q;

    logic        req0;
    logic        req1;
    logic        grant_vld;
    logic        grant_sel;
    logic        timeout_hit;

    logic        compl_any;
    logic        err_any;
    logic [31:0] rdata_any;

    assign req0      = bus.m0_cs && (|bus.m0_bytesel);
    assign req1      = bus.m1_cs && (|bus.m1_bytesel);
    assign grant_vld = req0 || req1;
    // On a tie the requester that did not win last time gets the bus.
    assign grant_sel = (req0 && req1) ? ~last_grant : req1;

    assign timeout_hit = (TIMEOUT != 16'd0) && (counter == (TIMEOUT - 16'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        compl_any = 1'b0;
        err_any   = 1'b0;
        rdata_any = 32'd0;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                // A real completion beats the watchdog in the same cycle.
                if (bus.s_compl) begin
                    compl_any = 1'b1;
                    rdata_any = bus.s_rdata;
                    state_nx  = IDLE;
                end else if (timeout_hit) begin
                    compl_any = 1'b1;
                    err_any   = 1'b1;
                    state_nx  = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.s_compl) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner       <= 1'b0;
            last_grant  <= 1'b1;
            counter     <= 16'd0;
            s_cs_q      <= 1'b0;
            s_addr_q    <= 32'd0;
            s_wdata_q   <= 32'd0;
            s_wr_en_q   <= 1'b0;
            s_bytesel_q <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        owner       <= grant_sel;
                        last_grant  <= grant_sel;
                        counter     <= 16'd0;
                        s_cs_q      <= 1'b1;
                        s_addr_q    <= grant_sel ? bus.m1_addr    : bus.m0_addr;
                        s_wdata_q   <= grant_sel ? bus.m1_wdata   : bus.m0_wdata;
                        s_wr_en_q   <= grant_sel ? bus.m1_wr_en   : bus.m0_wr_en;
                        s_bytesel_q <= grant_sel ? bus.m1_bytesel : bus.m0_bytesel;
                    end else begin
                        s_cs_q      <= 1'b0;
                        s_addr_q    <= 32'd0;
                        s_wdata_q   <= 32'd0;
                        s_wr_en_q   <= 1'b0;
                        s_bytesel_q <= 4'd0;
                    end
                end
                GRANT, DRAIN: begin
                    if ((state == GRANT) && (counter != 16'hFFFF)) begin
                        counter <= counter + 16'd1;
                    end
                    if (state_nx == IDLE) begin
                        s_cs_q      <= 1'b0;
                        s_addr_q    <= 32'd0;
                        s_wdata_q   <= 32'd0;
                        s_wr_en_q   <= 1'b0;
                        s_bytesel_q <= 4'd0;
                    end
                end
                default: begin
                    s_cs_q      <= 1'b0;
                    s_bytesel_q <= 4'd0;
                end
            endcase
        end
    end

    assign bus.s_cs      = s_cs_q;
    assign bus.s_addr    = s_addr_q;
    assign bus.s_wdata   = s_wdata_q;
    assign bus.s_wr_en   = s_wr_en_q;
    assign bus.s_bytesel = s_bytesel_q;

    // Return path is gated by owner so the other requester always sees zeros.
    assign bus.m0_compl = compl_any && !owner;
    assign bus.m0_err   = err_any   && !owner;
    assign bus.m0_rdata = owner ? 32'd0 : rdata_any;
    assign bus.m1_compl = compl_any && owner;
    assign bus.m1_err   = err_any   && owner;
    assign bus.m1_rdata = owner ? rdata_any : 32'd0;

    assign state_dbg = state;

endmodule

// File: tb/tb_bus_arbiter_2.sv
// Directed bench for bus_arbiter_2: a vector table of single transactions plus
// hand-written sequences for contention, watchdog, race and reset.
module tb_bus_arbiter_2;

    logic       clk;
    logic       rst;
    logic [1:0] state_dbg;
    int         total;
    int         bad;

    bus_arbiter_2_if bus ();

    bus_arbiter_2 #(.TIMEOUT(16'd8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    typedef struct {
        logic [1:0]  req;
        logic [31:0] m0_addr;
        logic [31:0] m0_wdata;
        logic        m0_wr;
        logic [3:0]  m0_bs;
        logic [31:0] m1_addr;
        logic [31:0] m1_wdata;
        logic        m1_wr;
        logic [3:0]  m1_bs;
        int          lat;
        logic [31:0] rdata;
        logic        exp_owner;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic        exp_wr;
        logic [3:0]  exp_bs;
    } vec_t;

    vec_t vecs[6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_reqs();
        bus.m0_cs      = 1'b0;
        bus.m0_addr    = 32'd0;
        bus.m0_wdata   = 32'd0;
        bus.m0_wr_en   = 1'b0;
        bus.m0_bytesel = 4'd0;
        bus.m1_cs      = 1'b0;
        bus.m1_addr    = 32'd0;
        bus.m1_wdata   = 32'd0;
        bus.m1_wr_en   = 1'b0;
        bus.m1_bytesel = 4'd0;
    endtask

    task automatic check_compl(input string tag, input logic c0, input logic e0,
                               input logic [31:0] r0, input logic c1,
                               input logic e1, input logic [31:0] r1);
        chk({tag, " m0_compl"}, 32'(bus.m0_compl), 32'(c0));
        chk({tag, " m0_err"},   32'(bus.m0_err),   32'(e0));
        chk({tag, " m0_rdata"}, bus.m0_rdata, r0);
        chk({tag, " m1_compl"}, 32'(bus.m1_compl), 32'(c1));
        chk({tag, " m1_err"},   32'(bus.m1_err),   32'(e1));
        chk({tag, " m1_rdata"}, bus.m1_rdata, r1);
    endtask

    task automatic check_s(input string tag, input logic cs, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic wr, input logic [3:0] bs);
        chk({tag, " s_cs"},      32'(bus.s_cs), 32'(cs));
        chk({tag, " s_addr"},    bus.s_addr, addr);
        chk({tag, " s_wdata"},   bus.s_wdata, wdata);
        chk({tag, " s_wr_en"},   32'(bus.s_wr_en), 32'(wr));
        chk({tag, " s_bytesel"}, 32'(bus.s_bytesel), 32'(bs));
    endtask

    // One transaction from IDLE through completion back to IDLE.
    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        bus.m0_cs      = v.req[0];
        bus.m0_addr    = v.m0_addr;
        bus.m0_wdata   = v.m0_wdata;
        bus.m0_wr_en   = v.m0_wr;
        bus.m0_bytesel = v.m0_bs;
        bus.m1_cs      = v.req[1];
        bus.m1_addr    = v.m1_addr;
        bus.m1_wdata   = v.m1_wdata;
        bus.m1_wr_en   = v.m1_wr;
        bus.m1_bytesel = v.m1_bs;
        tick();
        check_s({tag, " grant"}, 1'b1, v.exp_addr, v.exp_wdata, v.exp_wr, v.exp_bs);
        // Requester fields change during GRANT; the bridge must not see it.
        bus.m0_addr  = ~v.m0_addr;
        bus.m0_wdata = ~v.m0_wdata;
        bus.m1_addr  = ~v.m1_addr;
        bus.m1_wdata = ~v.m1_wdata;
        bus.m0_bytesel = 4'hF;
        bus.m1_bytesel = 4'hF;
        repeat (v.lat) tick();
        bus.s_rdata = v.rdata;
        bus.s_compl = 1'b1;
        #1;
        check_s({tag, " hold"}, 1'b1, v.exp_addr, v.exp_wdata, v.exp_wr, v.exp_bs);
        if (v.exp_owner)
            check_compl({tag, " done"}, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, v.rdata);
        else
            check_compl({tag, " done"}, 1'b1, 1'b0, v.rdata, 1'b0, 1'b0, 32'd0);
        tick();
        bus.s_compl = 1'b0;
        bus.s_rdata = 32'h0BAD_0BAD;
        clear_reqs();
        check_s({tag, " idle"}, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        check_compl({tag, " idle"}, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        clear_reqs();
        bus.s_rdata = 32'd0;
        bus.s_compl = 1'b0;

        //             req    m0_addr       m0_wdata      wr    bs     m1_addr       m1_wdata      wr    bs     lat rdata         own   exp_addr      exp_wdata     wr    bs
        vecs[0] = '{2'b01, 32'h0000_0100, 32'h0,        1'b0, 4'hF, 32'h0,        32'h0,        1'b0, 4'h0, 6, 32'hCAFE_F00D, 1'b0, 32'h0000_0100, 32'h0,        1'b0, 4'hF};
        vecs[1] = '{2'b10, 32'h0,        32'h0,        1'b0, 4'h0, 32'h0000_2000, 32'h1234_5678, 1'b1, 4'hC, 3, 32'hDEAD_BEEF, 1'b1, 32'h0000_2000, 32'h1234_5678, 1'b1, 4'hC};
        vecs[2] = '{2'b11, 32'h0000_0300, 32'h1111_1111, 1'b0, 4'h3, 32'h0000_0400, 32'h2222_2222, 1'b1, 4'hF, 0, 32'h0303_0303, 1'b0, 32'h0000_0300, 32'h1111_1111, 1'b0, 4'h3};
        vecs[3] = '{2'b11, 32'h0000_0330, 32'h3333_3333, 1'b1, 4'hF, 32'h0000_0500, 32'h0000_A5A5, 1'b1, 4'h1, 2, 32'h0505_0505, 1'b1, 32'h0000_0500, 32'h0000_A5A5, 1'b1, 4'h1};
        vecs[4] = '{2'b10, 32'h0,        32'h0,        1'b0, 4'h0, 32'h0000_0604, 32'h0,        1'b0, 4'h8, 1, 32'h8765_4321, 1'b1, 32'h0000_0604, 32'h0,        1'b0, 4'h8};
        vecs[5] = '{2'b01, 32'hFFFF_FFFC, 32'h0,        1'b1, 4'hF, 32'h0,        32'h0,        1'b0, 4'h0, 4, 32'h1357_9BDF, 1'b0, 32'hFFFF_FFFC, 32'h0,        1'b1, 4'hF};

        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state.
        chk("reset state", 32'(state_dbg), 32'd0);
        check_s("reset", 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        check_compl("reset", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

        // cs with no byte enables is not a request; s_compl in IDLE is ignored.
        bus.m0_cs     = 1'b1;
        bus.m0_addr   = 32'h0000_0999;
        bus.s_compl   = 1'b1;
        bus.s_rdata   = 32'hFFFF_0000;
        #1;
        check_compl("idle s_compl", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        tick();
        bus.s_compl = 1'b0;
        chk("no-bytesel state", 32'(state_dbg), 32'd0);
        chk("no-bytesel s_cs", 32'(bus.s_cs), 32'd0);
        clear_reqs();
        tick();

        for (int i = 0; i < 6; i++) begin
            run_vec(i, vecs[i]);
        end

        // Contention after reset: m0 first, then strict alternation.
        do_reset();
        bus.m0_cs = 1'b1; bus.m0_addr = 32'h0000_00A0; bus.m0_bytesel = 4'hF;
        bus.m1_cs = 1'b1; bus.m1_addr = 32'h0000_00B0; bus.m1_bytesel = 4'hF;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rr%0d s_addr", k), bus.s_addr, (k % 2 == 0) ? 32'h0000_00A0 : 32'h0000_00B0);
            tick();
            bus.s_rdata = 32'h0000_1000 + 32'(k);
            bus.s_compl = 1'b1;
            #1;
            chk($sformatf("rr%0d m0_compl", k), 32'(bus.m0_compl), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rr%0d m1_compl", k), 32'(bus.m1_compl), (k % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            bus.s_compl = 1'b0;
            chk($sformatf("rr%0d gap s_cs", k), 32'(bus.s_cs), 32'd0);
        end
        clear_reqs();
        tick();

        // Watchdog: m1 last won, so m0 takes the tie; m1 waits through DRAIN.
        bus.m0_cs = 1'b1; bus.m0_addr = 32'h0000_0700; bus.m0_bytesel = 4'hF;
        bus.m1_cs = 1'b1; bus.m1_addr = 32'h0000_0800; bus.m1_bytesel = 4'h3;
        bus.s_rdata = 32'hA5A5_5A5A;
        tick();
        chk("to grant s_addr", bus.s_addr, 32'h0000_0700);
        repeat (6) tick();
        chk("to early m0_compl", 32'(bus.m0_compl), 32'd0);
        tick();
        check_compl("to fire", 1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 32'd0);
        tick();
        bus.m0_cs = 1'b0;
        chk("drain state", 32'(state_dbg), 32'd2);
        check_s("drain", 1'b1, 32'h0000_0700, 32'd0, 1'b0, 4'hF);
        tick();
        tick();
        check_compl("drain wait", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        bus.s_compl = 1'b1;
        #1;
        check_compl("drain absorb", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        tick();
        bus.s_compl = 1'b0;
        chk("drain exit s_cs", 32'(bus.s_cs), 32'd0);
        tick();
        check_s("m1 after drain", 1'b1, 32'h0000_0800, 32'd0, 1'b0, 4'h3);
        bus.s_rdata = 32'h0800_0800;
        bus.s_compl = 1'b1;
        #1;
        check_compl("m1 after drain", 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h0800_0800);
        tick();
        bus.s_compl = 1'b0;
        clear_reqs();
        tick();

        // Race: s_compl lands exactly when the watchdog would fire.
        bus.m0_cs = 1'b1; bus.m0_addr = 32'h0000_0A00; bus.m0_bytesel = 4'hF;
        tick();
        repeat (7) tick();
        bus.s_rdata = 32'h5555_AAAA;
        bus.s_compl = 1'b1;
        #1;
        check_compl("race", 1'b1, 1'b0, 32'h5555_AAAA, 1'b0, 1'b0, 32'd0);
        tick();
        bus.s_compl = 1'b0;
        clear_reqs();
        chk("race back to idle", 32'(state_dbg), 32'd0);
        tick();

        // Asynchronous reset in the middle of GRANT.
        bus.m1_cs = 1'b1; bus.m1_addr = 32'h0000_0C00; bus.m1_bytesel = 4'hF;
        tick();
        tick();
        bus.s_rdata = 32'h0C0C_0C0C;
        bus.s_compl = 1'b1;
        #1;
        chk("pre-rst m1_compl", 32'(bus.m1_compl), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst s_cs", 32'(bus.s_cs), 32'd0);
        chk("rst s_bytesel", 32'(bus.s_bytesel), 32'd0);
        check_compl("rst", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        bus.s_compl = 1'b0;
        clear_reqs();
        #1;
        rst = 1'b0;
        tick();
        run_vec(10, vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
